cla_word_sequencer: RTL and testbench
=====================================

// Module: cla_word_sequencer
// PURPOSE
//  Multi-cycle wide-operand adder controller. Sequences one WIDTH-bit carry-lookahead slice
//  over NWORDS chunks, LSW first, registering the carry between chunks.
//  Produces an NWORDS*WIDTH-bit sum, carry-out and signed overflow.
//  Sits between a requester (valid/ready) and a consumer (valid/ready) on the arithmetic path.
//  Trades NWORDS cycles of latency for one WIDTH-bit lookahead slice.
// PARAMETERS
//  WIDTH   8  bits per chunk; lookahead slice width; >=2
//  NWORDS  4  chunks per operand; total operand width TW = WIDTH*NWORDS; >=2
// PORTS
//  clk       in   1    clock, rising edge
//  rstN      in   1    asynchronous active-low reset
//  inValid   in   1    operands/cIn valid
//  inReady   out  1    block can accept operands
//  a         in   TW   operand A
//  b         in   TW   operand B
//  cIn       in   1    carry into chunk 0
//  opSub     in   1    1 = A-B (effective only with CLA_SUB_EN)
//  outValid  out  1    result valid
//  outReady  in   1    consumer accepts result
//  sum       out  TW   result, unsigned modulo 2^TW
//  cOut      out  1    carry out of the MSB of the last chunk
//  ovf       out  1    signed overflow = carry into MSB XOR carry out of MSB
// BEHAVIOUR
//  - Reset (rstN low, async): state IDLE, chunk index 0, carry reg 0;
//    sum/cOut/ovf = 0, outValid = 0, inReady = 1.
//  - FSM IDLE -> RUN -> DONE -> IDLE.
//    - inReady = (state==IDLE); outValid = (state==DONE).
//  - IDLE: on inValid&&inReady, at that edge:
//    - latch a, b; carry reg <= cIn; idx <= 0; go to RUN.
//  - RUN, one chunk per cycle:
//    - slice computes a[idx], b[idx], carry reg -> sum word idx and chunk carry.
//    - at the edge: write sum word idx; carry reg <= chunk carry; idx++.
//    - when idx==NWORDS-1: also load cOut and ovf, go to DONE.
//  - Latency: outValid rises exactly NWORDS cycles after the accept edge.
//  - DONE: sum/cOut/ovf held stable until outValid&&outReady, then IDLE.
//    - inReady is 1 on the following cycle; no same-cycle accept/complete.
//  - While not IDLE, inValid is ignored; a/b/cIn changes have no effect.
//  - sum words not yet written during RUN hold the previous result.
//    They are don't-care until outValid.
//  - Reset mid-RUN or mid-DONE: operation aborted, result discarded, no outValid.
//  - Carry ripples through all chunks with no early termination.
//    Latency is data-independent.
// CONFIGURATION
//  - CLA_SUB_EN defined:
//    - opSub latched at accept.
//    - If 1: B is inverted per chunk; chunk-0 carry = cIn | opSub, so A-B = A+~B+1.
//    - cOut = 1 means no borrow.
//  - CLA_SUB_EN undefined: opSub port present but ignored; always A+B+cIn.
// STRUCTURE
//  - Package cla_pkg:
//    - typedef enum logic [1:0] {IDLE, RUN, DONE} claSeqState_t
//    - localparam function for index width $clog2(NWORDS)
//  - Sub-module cla_slice #(WIDTH):
//    - g = a&b, p = a^b; carry chain c[i] = g[i] | p[i]&c[i-1] from cIn.
//    - outputs sum = p ^ {c[WIDTH-2:0],cIn}, cOut = c[WIDTH-1], cMsbIn = c[WIDTH-2].
//  - Sequencer owns FSM, idx counter, carry reg, operand/result regs.
// TESTING (WIDTH=8, NWORDS=4)
//  1. a=0x000000FF, b=0x1, cIn=0 -> sum=0x00000100, cOut=0, ovf=0; outValid 4 cycles after accept.
//  2. a=0xFFFFFFFF, b=0x1, cIn=0 -> sum=0x00000000, cOut=1, ovf=0 (carry crosses all 4 chunks).
//  3. a=0x7FFFFFFF, b=0x1 -> sum=0x80000000, cOut=0, ovf=1.
//     a=0x80000000, b=0x80000000 -> sum=0, cOut=1, ovf=1.
//  4. outReady=0 for 5 cycles in DONE, inValid=1 with new operands:
//     -> sum stable, inReady=0, new operands not taken.
//     outReady=1 -> IDLE, inReady=1 next cycle.
//  5. rstN low for 1 cycle at idx=2 of RUN:
//     -> outValid stays 0, inReady=1, sum=0.
//     Next op 0x12345678+0x11111111 -> 0x23456789.
//  6. CLA_SUB_EN: a=5, b=7, opSub=1 -> sum=0xFFFFFFFE, cOut=0.
//     Without macro, same stimulus -> sum=0x0000000C, cOut=0.

Source files
------------

// File: rtl/cla_word_sequencer_pkg.sv
// Shared types for the multi-cycle carry-lookahead word sequencer.
// Holds the sequencer state encoding and the chunk-index width helper.
package cla_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } claSeqState_t;

    function automatic int unsigned idx_width(input int unsigned nwords);
        return (nwords <= 1) ? 1 : $clog2(nwords);
    endfunction

endpackage

// File: rtl/cla_word_sequencer_if.sv
// Request/response bundle between requester, sequencer and consumer.
// The sequencer takes the slave view; the requester/consumer side takes master.
interface cla_word_sequencer_if #(
    parameter int unsigned TW = 32
);
    logic          inValid;
    logic          inReady;
    logic [TW-1:0] a;
    logic [TW-1:0] b;
    logic          cIn;
    logic          opSub;
    logic          outValid;
    logic          outReady;
    logic [TW-1:0] sum;
    logic          cOut;
    logic          ovf;

    modport master (
        output inValid, a, b, cIn, opSub, outReady,
        input  inReady, outValid, sum, cOut, ovf
    );

    modport slave (
        input  inValid, a, b, cIn, opSub, outReady,
        output inReady, outValid, sum, cOut, ovf
    );
endinterface

// File: rtl/cla_word_sequencer_slice.sv
// One WIDTH-bit adder slice: generate/propagate terms and carry chain.
// Also exposes the carry into the MSB so the caller can derive signed overflow.
module cla_slice #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cIn,
    output logic [WIDTH-1:0] sum,
    output logic             cOut,
    output logic             cMsbIn
);
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] c;

    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        c[0] = g[0] | (p[0] & cIn);
        for (int unsigned i = 1; i < WIDTH; i++) begin
            c[i] = g[i] | (p[i] & c[i-1]);
        end
    end

    assign sum    = p ^ {c[WIDTH-2:0], cIn};
    assign cOut   = c[WIDTH-1];
    assign cMsbIn = c[WIDTH-2];
endmodule

// File: rtl/cla_word_sequencer.sv
// Wide adder that runs one cla_slice over NWORDS chunks, LSW first, carry registered.
// Define CLA_SUB_EN to honour opSub (A-B as A+~B+1); otherwise opSub is ignored.
module cla_word_sequencer
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned NWORDS = 4
) (
    input logic                clk,
    input logic                rstN,
    cla_word_sequencer_if.slave bus
);
    localparam int unsigned TW = WIDTH * NWORDS;
    localparam int unsigned IW = idx_width(NWORDS);
    localparam logic [IW-1:0] LAST_IDX = IW'(NWORDS - 1);

    claSeqState_t   state;
    logic [IW-1:0]  idx;
    logic           carry;
    logic [TW-1:0]  a_reg;
    logic [TW-1:0]  b_reg;
    logic [TW-1:0]  sum_reg;
    logic           c_out_reg;
    logic           ovf_reg;
    logic           in_ready;
    logic           out_valid;
    logic           sub_reg;

    logic [WIDTH-1:0] a_word;
    logic [WIDTH-1:0] b_word;
    logic [WIDTH-1:0] s_word;
    logic             s_cout;
    logic             s_msb_in;

    always_comb begin
        a_word = '0;
        b_word = '0;
        for (int unsigned i = 0; i < NWORDS; i++) begin
            if (idx == IW'(i)) begin
                a_word = a_reg[i*WIDTH +: WIDTH];
                b_word = b_reg[i*WIDTH +: WIDTH];
            end
        end
        if (sub_reg) begin
            b_word = ~b_word;
        end
    end

    cla_slice #(.WIDTH(WIDTH)) u_slice (
        .a      (a_word),
        .b      (b_word),
        .cIn    (carry),
        .sum    (s_word),
        .cOut   (s_cout),
        .cMsbIn (s_msb_in)
    );

`ifndef CLA_SUB_EN
    logic unused_op_sub;
    assign unused_op_sub = bus.opSub;
`endif

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state     <= IDLE;
            idx       <= '0;
            carry     <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            c_out_reg <= 1'b0;
            ovf_reg   <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            sub_reg   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.inValid) begin
                        a_reg    <= bus.a;
                        b_reg    <= bus.b;
                        idx      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
`ifdef CLA_SUB_EN
                        sub_reg  <= bus.opSub;
                        carry    <= bus.cIn | bus.opSub;
`else
                        sub_reg  <= 1'b0;
                        carry    <= bus.cIn;
`endif
                    end
                end
                RUN: begin
                    for (int unsigned i = 0; i < NWORDS; i++) begin
                        if (idx == IW'(i)) begin
                            sum_reg[i*WIDTH +: WIDTH] <= s_word;
                        end
                    end
                    carry <= s_cout;
                    idx   <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        // Flags come straight from the last chunk's slice outputs.
                        c_out_reg <= s_cout;
                        ovf_reg   <= s_cout ^ s_msb_in;
                        idx       <= '0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.outReady) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.inReady  = in_ready;
    assign bus.outValid = out_valid;
    assign bus.sum      = sum_reg;
    assign bus.cOut     = c_out_reg;
    assign bus.ovf      = ovf_reg;
endmodule

// File: tb/tb_cla_word_sequencer.sv
// Bench for cla_word_sequencer (WIDTH=8, NWORDS=4): whole-word arithmetic model,
// per-cycle compare against it, plus directed vectors with literal expectations.
module tb_cla_word_sequencer;
    localparam int unsigned WIDTH  = 8;
    localparam int unsigned NWORDS = 4;
    localparam int unsigned TW     = WIDTH * NWORDS;

    logic clk;
    logic rstN;
    int   checks;
    int   errors;

    cla_word_sequencer_if #(.TW(TW)) bus ();

    cla_word_sequencer #(.WIDTH(WIDTH), .NWORDS(NWORDS)) dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // {ovf, cOut, sum} from whole-operand arithmetic.
    function automatic logic [TW+1:0] model_add(input logic [TW-1:0] ma, input logic [TW-1:0] mb,
                                                input logic mc, input logic ms);
        logic          sub;
        logic [TW-1:0] bb;
        logic [TW:0]   full;
        logic          v;
`ifdef CLA_SUB_EN
        sub = ms;
`else
        sub = 1'b0 & ms;
`endif
        bb   = sub ? ~mb : mb;
        full = {1'b0, ma} + {1'b0, bb} + {{TW{1'b0}}, (mc | sub)};
        v    = (ma[TW-1] == bb[TW-1]) && (full[TW-1] != ma[TW-1]);
        return {v, full[TW], full[TW-1:0]};
    endfunction

    // Model: 0 idle, 1 busy, 2 result held.
    int              m_phase;
    int              m_cnt;
    logic [TW+1:0]   m_pend;
    logic [TW+1:0]   m_res;

    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            m_phase = 0;
            m_cnt   = 0;
            m_res   = '0;
            m_pend  = '0;
        end else begin
            case (m_phase)
                0: if (bus.inValid) begin
                    m_pend  = model_add(bus.a, bus.b, bus.cIn, bus.opSub);
                    m_cnt   = NWORDS;
                    m_phase = 1;
                end
                1: begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        m_phase = 2;
                        m_res   = m_pend;
                    end
                end
                default: if (bus.outReady) m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        check("cmp_in_ready", bus.inReady, (m_phase == 0));
        check("cmp_out_valid", bus.outValid, (m_phase == 2));
        if (m_phase != 1) begin
            check("cmp_sum", bus.sum, m_res[TW-1:0]);
            check("cmp_cout", bus.cOut, m_res[TW]);
            check("cmp_ovf", bus.ovf, m_res[TW+1]);
        end
    end

    task automatic start_op(input logic [TW-1:0] ta, input logic [TW-1:0] tbv,
                            input logic tc, input logic ts, output int lat);
        int w;
        w = 0;
        while (!bus.inReady && w < 20) begin
            @(posedge clk); #1; w++;
        end
        bus.a = ta; bus.b = tbv; bus.cIn = tc; bus.opSub = ts; bus.inValid = 1'b1;
        @(posedge clk); #1;
        bus.inValid = 1'b0;
        // Operand changes after accept must not matter.
        bus.a = 32'hA5A5_5A5A; bus.b = 32'h3C3C_C3C3; bus.cIn = ~tc;
        lat = 0;
        while (!bus.outValid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic consume();
        bus.outReady = 1'b1;
        @(posedge clk); #1;
        bus.outReady = 1'b0;
    endtask

    typedef struct {
        logic [TW-1:0] a;
        logic [TW-1:0] b;
        logic          c;
        logic          s;
        logic [TW-1:0] sum;
        logic          co;
        logic          v;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int lat;
        checks = 0; errors = 0;
        rstN = 1'b0;
        bus.inValid = 1'b0; bus.outReady = 1'b0;
        bus.a = '0; bus.b = '0; bus.cIn = 1'b0; bus.opSub = 1'b0;

        check("model_pin_ff", model_add(32'h0000_00FF, 32'h1, 1'b0, 1'b0), {2'b00, 32'h0000_0100});
        check("model_pin_ovf", model_add(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0), {2'b11, 32'h0});

        repeat (2) @(posedge clk);
        #1 rstN = 1'b1;
        check("rst_in_ready", bus.inReady, 1'b1);
        check("rst_out_valid", bus.outValid, 1'b0);
        check("rst_sum", bus.sum, 32'h0);

        vecs.push_back('{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0});
        vecs.push_back('{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0});
        vecs.push_back('{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1});
        vecs.push_back('{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1});
        vecs.push_back('{32'h0000_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0001_0000, 1'b0, 1'b0});
        vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0});
`ifdef CLA_SUB_EN
        vecs.push_back('{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0});
`else
        vecs.push_back('{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'h0000_000C, 1'b0, 1'b0});
`endif

        foreach (vecs[i]) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].s, lat);
            check($sformatf("vec%0d_latency", i), lat, NWORDS);
            check($sformatf("vec%0d_sum", i), bus.sum, vecs[i].sum);
            check($sformatf("vec%0d_cout", i), bus.cOut, vecs[i].co);
            check($sformatf("vec%0d_ovf", i), bus.ovf, vecs[i].v);
            consume();
            check($sformatf("vec%0d_ready_after", i), bus.inReady, 1'b1);
        end

        // Backpressure in DONE with a competing request.
        start_op(32'h0102_0304, 32'h1020_3040, 1'b0, 1'b0, lat);
        bus.a = 32'hDEAD_BEEF; bus.b = 32'h1111_1111; bus.inValid = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            check("hold_in_ready", bus.inReady, 1'b0);
            check("hold_out_valid", bus.outValid, 1'b1);
            check("hold_sum", bus.sum, 32'h1122_3344);
        end
        bus.inValid = 1'b0;
        consume();
        check("hold_release_ready", bus.inReady, 1'b1);
        check("hold_release_valid", bus.outValid, 1'b0);
        check("hold_release_sum", bus.sum, 32'h1122_3344);

        // Reset at chunk index 2 of RUN.
        bus.a = 32'h0F0F_0F0F; bus.b = 32'h0101_0101; bus.cIn = 1'b0; bus.inValid = 1'b1;
        @(posedge clk); #1;
        bus.inValid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstN = 1'b0;
        #1;
        check("abort_in_ready", bus.inReady, 1'b1);
        check("abort_out_valid", bus.outValid, 1'b0);
        check("abort_sum", bus.sum, 32'h0);
        @(posedge clk); #1 rstN = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            check("post_abort_valid", bus.outValid, 1'b0);
        end
        start_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, lat);
        check("post_abort_latency", lat, NWORDS);
        check("post_abort_sum", bus.sum, 32'h2345_6789);
        consume();

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end
endmodule
